break_gen: RTL and testbench
============================

BREAK_GEN -- requirements
Module: break_gen

Interface
REQ-001 Parameter DRAIN_MIN, default 4: minimum cycles in DRAIN before halt; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 100000: idle-commit cycles before watchdog halt; used only with BREAK_GEN_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: reset=0 sampled at a rising clk edge resets the block.
REQ-005 cmt_valid  input  1  one instruction retires this cycle.
REQ-006 cmt_pc  input  32  PC of the retiring instruction.
REQ-007 cmt_inst  input  32  encoding of the retiring instruction.
REQ-008 cmt_a0  input  32  architectural r4 (a0) value after this retirement.
REQ-009 mem_busy  input  1  memory/store transaction outstanding.
REQ-010 is_break  output  1  halt request to the simulation bench; level, held until reset.
REQ-011 break_pc  output  32  PC of the halting instruction.
REQ-012 exit_code  output  32  a0 value at halt, or the watchdog code.
REQ-013 inst_cnt  output  32  retired-instruction count.
REQ-014 cycle_cnt  output  32  cycles since reset release.

Function
REQ-015 Break match: cmt_valid=1 and cmt_inst[31:15]=17'h00054; code field cmt_inst[14:0] is ignored.
REQ-016 FSM states: RUN, DRAIN, HALT; all outputs registered.
REQ-017 RUN: cycle_cnt +1 every cycle; inst_cnt +1 per cmt_valid=1 cycle.
REQ-018 RUN plus break match at edge T: the same edge latches break_pc=cmt_pc and exit_code=cmt_a0, counts the break in inst_cnt, clears drain_cnt and enters DRAIN.
REQ-019 DRAIN: cmt_valid is ignored and inst_cnt is frozen; cycle_cnt keeps counting; drain_cnt +1 per cycle.
REQ-020 DRAIN to HALT when drain_cnt=DRAIN_MIN-1 and mem_busy=0; if mem_busy=1, stay in DRAIN (drain_cnt saturates) until mem_busy=0.
REQ-021 Latency: break committed at edge T, mem_busy=0 throughout -> is_break=1 after edge T+DRAIN_MIN.
REQ-022 HALT: is_break=1; break_pc, exit_code, inst_cnt and cycle_cnt frozen; all inputs ignored until reset.
REQ-023 inst_cnt and cycle_cnt saturate at 32'hFFFFFFFF; they never wrap.
REQ-024 A second break match while in DRAIN or HALT has no effect; the first break's PC and a0 are kept.

Reset
REQ-025 reset=0 at an edge: state=RUN; is_break=0; break_pc, exit_code, inst_cnt, cycle_cnt, drain_cnt and watchdog all 0.
REQ-026 Reset has priority over every event, including a break match in the same cycle, and aborts DRAIN or HALT immediately.
REQ-027 cycle_cnt counts from the first edge with reset=1.

Configuration
REQ-028 Macro BREAK_GEN_TIMEOUT_EN, when defined: a watchdog counter active only in RUN clears on cmt_valid=1 and otherwise increments.
REQ-029 With the macro, watchdog reaching TIMEOUT-1 enters DRAIN with exit_code=32'hDEAD0001 and break_pc=PC of the last retired instruction (0 if none); a break match in the same cycle takes priority.
REQ-030 Without the macro, no watchdog logic exists; only a break match leaves RUN, and TIMEOUT is unused.

Verification
REQ-031 Break: 10 non-break commits, then inst 32'h002A0000, pc 32'h1C000100, a0 0 -> is_break=1 exactly DRAIN_MIN cycles later; break_pc=32'h1C000100; exit_code=0; inst_cnt=11.
REQ-032 Drain stall: break with mem_busy=1 held 20 cycles -> is_break stays 0 until the edge after mem_busy falls; cycle_cnt keeps counting through the stall.
REQ-033 Double break: break a0=5, then another break a0=7 one cycle later -> exit_code=5; inst_cnt counts only the first.
REQ-034 Reset race: reset=0 in the same cycle as a break, then 5 idle cycles -> is_break=0 and all counters 0 at reset release; a later break halts normally.
REQ-035 Reset in HALT: reset=0 for one cycle -> is_break=0, state RUN; cycle_cnt counts from 0.
REQ-036 Watchdog (macro defined, TIMEOUT=50): one commit at pc 32'h1C000000, then none -> exit_code=32'hDEAD0001, break_pc=32'h1C000000, is_break after 50+DRAIN_MIN cycles; macro undefined -> is_break stays 0.

Source files
------------

// File: rtl/break_gen_if.sv
// Commit/halt bundle between the retiring core (or bench) and break_gen.
interface break_gen_if;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic [31:0] cmt_a0;
  logic        mem_busy;
  logic        is_break;
  logic [31:0] break_pc;
  logic [31:0] exit_code;
  logic [31:0] inst_cnt;
  logic [31:0] cycle_cnt;

  modport master (
    output cmt_valid, cmt_pc, cmt_inst, cmt_a0, mem_busy,
    input  is_break, break_pc, exit_code, inst_cnt, cycle_cnt
  );

  modport slave (
    input  cmt_valid, cmt_pc, cmt_inst, cmt_a0, mem_busy,
    output is_break, break_pc, exit_code, inst_cnt, cycle_cnt
  );
endinterface

// File: rtl/break_gen.sv
// Simulation halt generator: watches retirements for a break instruction, drains outstanding
// memory traffic for at least DRAIN_MIN cycles, then raises is_break until reset.
// Optional macro BREAK_GEN_TIMEOUT_EN adds an idle-commit watchdog that halts with 32'hDEAD0001.
module break_gen #(
  parameter int unsigned DRAIN_MIN = 4,
  parameter int unsigned TIMEOUT   = 100000
) (
  input logic        clk,
  input logic        reset,
  break_gen_if.slave bus
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  localparam logic [7:0]  DrainLast = 8'(DRAIN_MIN - 1);
  localparam logic [16:0] BreakOp   = 17'h00054;
  localparam logic [31:0] WdogCode  = 32'hDEAD0001;

  state_e      state_q, state_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] break_pc_q, break_pc_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        brk_hit;
  logic        wdog_hit;
  logic [31:0] wdog_pc;
  logic        unused_code;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  // The break code field is deliberately ignored.
  assign brk_hit     = bus.cmt_valid && (bus.cmt_inst[31:15] == BreakOp);
  assign unused_code = ^bus.cmt_inst[14:0];

`ifdef BREAK_GEN_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] last_pc_q, last_pc_d;

  // Watchdog: idle-commit counter and last retired PC, both only advance in RUN.
  always_comb begin
    wdog_d    = wdog_q;
    last_pc_d = last_pc_q;
    if (state_q == StRun) begin
      if (bus.cmt_valid) begin
        wdog_d    = '0;
        last_pc_d = bus.cmt_pc;
      end else begin
        wdog_d = sat_inc(wdog_q);
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog_q    <= '0;
      last_pc_q <= '0;
    end else begin
      wdog_q    <= wdog_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign wdog_hit = !bus.cmt_valid && (wdog_q == 32'(TIMEOUT - 1));
  assign wdog_pc  = last_pc_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_pc  = '0;

  // TIMEOUT only matters when the watchdog is built in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // State and datapath registers; reset overrides everything, including a same-cycle break.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      break_pc_q  <= '0;
      exit_code_q <= '0;
      inst_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      break_pc_q  <= break_pc_d;
      exit_code_q <= exit_code_d;
      inst_cnt_q  <= inst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    break_pc_d  = break_pc_q;
    exit_code_d = exit_code_q;
    inst_cnt_d  = inst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    unique case (state_q)
      StRun: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        if (bus.cmt_valid) inst_cnt_d = sat_inc(inst_cnt_q);
        if (brk_hit) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
          break_pc_d  = bus.cmt_pc;
          exit_code_d = bus.cmt_a0;
        end else if (wdog_hit) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
          break_pc_d  = wdog_pc;
          exit_code_d = WdogCode;
        end
      end
      StDrain: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        // Counter parks at its last value while memory is still busy.
        if (drain_cnt_q == DrainLast) begin
          if (!bus.mem_busy) state_d = StHalt;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      StHalt: begin
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.is_break  = (state_q == StHalt);
    bus.break_pc  = break_pc_q;
    bus.exit_code = exit_code_q;
    bus.inst_cnt  = inst_cnt_q;
    bus.cycle_cnt = cycle_cnt_q;
  end

endmodule

// File: tb/tb_break_gen.sv
// Self-checking bench for break_gen: expected halt records are queued when a break is
// driven and compared when is_break rises.
module tb_break_gen;
  localparam int unsigned DrainMin = 4;
  localparam int unsigned Timeout  = 50;
  localparam logic [31:0] BrkInst  = 32'h002A0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] code;
    logic [31:0] icnt;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_cyc = 0;
  bit   m_counting = 1'b0;

  always #5 clk = ~clk;

  break_gen_if bus ();

  break_gen #(
    .DRAIN_MIN(DrainMin),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (m_counting) m_cyc++;
  endtask

  function automatic logic [31:0] nb_inst();
    logic [31:0] v;
    v = $urandom;
    if (v[31:15] == 17'h00054) v[31] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    bus.cmt_valid = 1'b0;
    bus.cmt_pc    = '0;
    bus.cmt_inst  = '0;
    bus.cmt_a0    = '0;
    bus.mem_busy  = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a0);
    bus.cmt_valid = 1'b1;
    bus.cmt_pc    = pc;
    bus.cmt_inst  = inst;
    bus.cmt_a0    = a0;
    tick();
    bus.cmt_valid = 1'b0;
    bus.cmt_inst  = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    m_counting = 1'b0;
    idle();
    repeat (n) tick();
    check("rst_is_break", {31'd0, bus.is_break}, 32'd0);
    check("rst_break_pc", bus.break_pc, 32'd0);
    check("rst_exit_code", bus.exit_code, 32'd0);
    check("rst_inst_cnt", bus.inst_cnt, 32'd0);
    check("rst_cycle_cnt", bus.cycle_cnt, 32'd0);
    reset = 1'b1;
    m_cyc = 0;
    m_counting = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] icnt,
                      input int lat);
    exp_t e;
    e.pc = pc;
    e.code = code;
    e.icnt = icnt;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits (bounded) for is_break, then pops the oldest expectation and compares.
  task automatic wait_break(input string tag, input int max_cyc);
    exp_t e;
    int   lat = 0;
    while (!bus.is_break && lat < max_cyc) begin
      tick();
      lat++;
    end
    m_counting = 1'b0;
    check({tag, "_halted"}, {31'd0, bus.is_break}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_break_pc"}, bus.break_pc, e.pc);
      check({tag, "_exit_code"}, bus.exit_code, e.code);
      check({tag, "_inst_cnt"}, bus.inst_cnt, e.icnt);
      check({tag, "_cycle_cnt"}, bus.cycle_cnt, 32'(m_cyc));
    end
  endtask

  initial begin
    bit stalled_ok;
    idle();

    // Basic break after ten ordinary commits.
    do_reset(3);
    tick();
    check("cyc_start", bus.cycle_cnt, 32'd1);
    for (int i = 0; i < 10; i++) commit(32'h1C000000 + 32'(4 * i), nb_inst(), $urandom);
    check("run_inst_cnt", bus.inst_cnt, 32'd10);
    check("run_cycle_cnt", bus.cycle_cnt, 32'(m_cyc));
    push(32'h1C000100, 32'd0, 32'd11, DrainMin);
    commit(32'h1C000100, BrkInst, 32'd0);
    wait_break("basic", 40);

    // HALT ignores everything, including another break.
    commit(32'h1C000200, nb_inst(), 32'd9);
    commit(32'h1C000204, BrkInst, 32'd9);
    bus.mem_busy = 1'b1;
    repeat (3) tick();
    bus.mem_busy = 1'b0;
    check("halt_is_break", {31'd0, bus.is_break}, 32'd1);
    check("halt_break_pc", bus.break_pc, 32'h1C000100);
    check("halt_exit_code", bus.exit_code, 32'd0);
    check("halt_inst_cnt", bus.inst_cnt, 32'd11);
    check("halt_cycle_cnt", bus.cycle_cnt, 32'(m_cyc));

    // Drain held off by mem_busy for 20 cycles.
    do_reset(2);
    commit(32'h1C000010, nb_inst(), 32'd1);
    bus.mem_busy = 1'b1;
    commit(32'h1C000014, BrkInst | 32'h0000_1234, 32'd3);
    stalled_ok = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (bus.is_break) stalled_ok = 1'b0;
    end
    check("stall_no_halt", {31'd0, stalled_ok}, 32'd1);
    check("stall_cycle_cnt", bus.cycle_cnt, 32'(m_cyc));
    bus.mem_busy = 1'b0;
    push(32'h1C000014, 32'd3, 32'd2, 1);
    wait_break("stall", 20);

    // Second break one cycle later is ignored.
    do_reset(2);
    for (int i = 0; i < 3; i++) commit(32'h1C000020 + 32'(4 * i), nb_inst(), 32'd0);
    push(32'h1C000040, 32'd5, 32'd4, DrainMin - 1);
    commit(32'h1C000040, BrkInst, 32'd5);
    commit(32'h1C000044, BrkInst | 32'd7, 32'd7);
    wait_break("double", 40);

    // Reset asserted in the same cycle as a break.
    reset = 1'b0;
    m_counting = 1'b0;
    commit(32'h1C000080, BrkInst, 32'd6);
    do_reset(5);
    commit(32'h1C000090, nb_inst(), 32'd0);
    commit(32'h1C000094, nb_inst(), 32'd0);
    push(32'h1C000098, 32'hCAFE0000, 32'd3, DrainMin);
    commit(32'h1C000098, BrkInst, 32'hCAFE0000);
    wait_break("race", 40);

    // One-cycle reset from HALT.
    do_reset(1);
    repeat (3) tick();
    check("rehalt_cycle_cnt", bus.cycle_cnt, 32'd3);
    check("rehalt_run", {31'd0, bus.is_break}, 32'd0);
    commit(32'h1C0000A0, nb_inst(), 32'd0);
    check("rehalt_inst_cnt", bus.inst_cnt, 32'd1);

    // Idle watchdog.
    do_reset(2);
    commit(32'h1C000000, nb_inst(), 32'd0);
`ifdef BREAK_GEN_TIMEOUT_EN
    push(32'h1C000000, 32'hDEAD0001, 32'd1, Timeout + DrainMin);
    wait_break("wdog", Timeout + DrainMin + 20);
`else
    repeat (Timeout + DrainMin + 20) tick();
    check("no_wdog_is_break", {31'd0, bus.is_break}, 32'd0);
    check("no_wdog_cycle_cnt", bus.cycle_cnt, 32'(m_cyc));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
